// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared sizes, state encoding and row type for the systolic array
package systolic_pkg;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 4;
  // Accumulator width the downstream array needs for an N-term dot product
  localparam int RES_W  = 2 * DW_DEF + $clog2(N_DEF) + 1;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FEED = 2'd1,
    DONE = 2'd2
  } feeder_state_t;

  typedef logic [N_DEF-1:0][DW_DEF-1:0] row_t;

endpackage

// File: rtl/systolic_skew_select.sv
// rtl/systolic_skew_select.sv - picks one zero-padded anti-diagonal of a buffered matrix
module systolic_skew_select #(
  parameter int N         = 4,
  parameter int DW        = 4,
  parameter int SW        = 3,
  parameter bit COL_MAJOR = 1'b0
) (
  input  logic                        en,
  input  logic [SW-1:0]               step,
  input  logic [N-1:0][N-1:0][DW-1:0] mat,
  output logic [N-1:0][DW-1:0]        diag
);

  // Lane i takes element k where i + k == step; row-major for A, column-major for B
  always_comb begin
    diag = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (en && (int'(step) == i + k)) begin
          diag[i] = COL_MAJOR ? mat[k][i] : mat[i][k];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_operand_feeder.sv
// rtl/systolic_operand_feeder.sv - buffers an N x N operand pair and drives the skewed wavefront
module systolic_operand_feeder
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [N-1:0][DW-1:0] in_a_row_i,
  input  logic [N-1:0][DW-1:0] in_b_row_i,
  output logic                 feed_valid_o,
  input  logic                 feed_ready_i,
  output logic [N-1:0][DW-1:0] a_west_o,
  output logic [N-1:0][DW-1:0] b_north_o,
  output logic                 feed_first_o,
  output logic                 feed_last_o,
  output logic                 done_o,
  output logic                 busy_o
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = (N > 1) ? $clog2(2 * N - 1) : 1;
  localparam logic [RW-1:0] ROW_LAST  = RW'(N - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(2 * N - 2);

  feeder_state_t               state_q, state_d;
  logic                        in_ready_q;
  logic [RW-1:0]               row_cnt_q;
  logic [SW-1:0]               step_q;
  logic [N-1:0][N-1:0][DW-1:0] a_buf_q, b_buf_q;
  logic                        accept, feed_fire, in_feed;

  assign accept    = in_valid_i && in_ready_q;
  assign in_feed   = (state_q == FEED);
  assign feed_fire = in_feed && feed_ready_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (accept && (row_cnt_q == ROW_LAST)) state_d = FEED;
      FEED:    if (feed_fire && (step_q == STEP_LAST)) state_d = DONE;
      DONE:    state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // in_ready tracks the next state so it stays registered yet opens right as LOAD begins
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= LOAD;
      in_ready_q <= 1'b0;
      row_cnt_q  <= '0;
      step_q     <= '0;
      a_buf_q    <= '0;
      b_buf_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == LOAD);
      if (accept) begin
        a_buf_q[row_cnt_q] <= in_a_row_i;
        b_buf_q[row_cnt_q] <= in_b_row_i;
        row_cnt_q          <= (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + 1'b1;
      end
      if (feed_fire) begin
        step_q <= (step_q == STEP_LAST) ? '0 : step_q + 1'b1;
      end
    end
  end

  systolic_skew_select #(.N(N), .DW(DW), .SW(SW), .COL_MAJOR(1'b0)) u_skew_a (
    .en   (in_feed),
    .step (step_q),
    .mat  (a_buf_q),
    .diag (a_west_o)
  );

  systolic_skew_select #(.N(N), .DW(DW), .SW(SW), .COL_MAJOR(1'b1)) u_skew_b (
    .en   (in_feed),
    .step (step_q),
    .mat  (b_buf_q),
    .diag (b_north_o)
  );

  assign in_ready_o   = in_ready_q;
  assign feed_valid_o = in_feed;
  assign feed_first_o = in_feed && (step_q == '0);
  assign feed_last_o  = in_feed && (step_q == STEP_LAST);
  assign done_o       = (state_q == DONE);
  assign busy_o       = (state_q == FEED) || (state_q == DONE);

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// tb/tb_systolic_operand_feeder.sv - directed self-checking bench for systolic_operand_feeder
module tb_systolic_operand_feeder;

  localparam int N  = 4;
  localparam int DW = 4;
  typedef logic [N-1:0][DW-1:0] vec_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic in_valid_i = 1'b0;
  logic feed_ready_i = 1'b1;
  vec_t in_a_row_i = '0;
  vec_t in_b_row_i = '0;
  logic in_ready_o, feed_valid_o, feed_first_o, feed_last_o, done_o, busy_o;
  vec_t a_west_o, b_north_o;

  int passed = 0;
  int total  = 0;

  vec_t cur_a [N];
  vec_t cur_b [N];
  vec_t m1a [N];
  vec_t m1b [N];
  vec_t m2a [N];
  vec_t m2b [N];

  always #5 clk_i = ~clk_i;

  systolic_operand_feeder #(.N(N), .DW(DW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_a_row_i   (in_a_row_i),
    .in_b_row_i   (in_b_row_i),
    .feed_valid_o (feed_valid_o),
    .feed_ready_i (feed_ready_i),
    .a_west_o     (a_west_o),
    .b_north_o    (b_north_o),
    .feed_first_o (feed_first_o),
    .feed_last_o  (feed_last_o),
    .done_o       (done_o),
    .busy_o       (busy_o)
  );

  function automatic vec_t exp_a(input int t);
    vec_t r = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) r[i] = cur_a[i][t - i];
    return r;
  endfunction

  function automatic vec_t exp_b(input int t);
    vec_t r = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) r[j] = cur_b[t - j][j];
    return r;
  endfunction

  task automatic load_pair(input int which, input bit gaps, output int cyc);
    int r = 0;
    bit pre;
    bit early_feed = 1'b0;
    cyc = 0;
    for (int k = 0; k < N; k++) begin
      cur_a[k] = (which == 1) ? m1a[k] : m2a[k];
      cur_b[k] = (which == 1) ? m1b[k] : m2b[k];
    end
    while (r < N && cyc < 100) begin
      in_valid_i = gaps ? (cyc % 2 == 0) : 1'b1;
      in_a_row_i = cur_a[r];
      in_b_row_i = cur_b[r];
      pre = in_ready_o;
      if (feed_valid_o) early_feed = 1'b1;
      @(posedge clk_i);
      if (in_valid_i && pre) r++;
      #1;
      cyc++;
    end
    in_valid_i = 1'b0;
    total++;
    if (r != N || early_feed) $display("FAIL load: rows %0d early_feed %0d required rows %0d early_feed 0", r, early_feed, N);
    else passed++;
  endtask

  task automatic run_feed(input int stall_at, input int stall_len, input int abort_at, output int cyc);
    int t = 0;
    int stalls = stall_len;
    bit rdy;
    bit fin = 1'b0;
    bit aborted = 1'b0;
    cyc = 0;
    while (!fin && !aborted && cyc < 100) begin
      if (t == abort_at) begin
        aborted = 1'b1;
      end else begin
        total++;
        if (feed_valid_o !== 1'b1 || in_ready_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 1'b0)
          $display("FAIL feed_ctrl t=%0d: valid %b ready %b busy %b done %b required 1 0 1 0", t, feed_valid_o, in_ready_o, busy_o, done_o);
        else passed++;
        total++;
        if (a_west_o !== exp_a(t)) $display("FAIL a_west t=%0d: got %h required %h", t, a_west_o, exp_a(t));
        else passed++;
        total++;
        if (b_north_o !== exp_b(t)) $display("FAIL b_north t=%0d: got %h required %h", t, b_north_o, exp_b(t));
        else passed++;
        total++;
        if (feed_first_o !== (t == 0) || feed_last_o !== (t == 2 * N - 2))
          $display("FAIL first_last t=%0d: got %b %b required %b %b", t, feed_first_o, feed_last_o, t == 0, t == 2 * N - 2);
        else passed++;
        rdy = !(t == stall_at && stalls > 0);
        if (!rdy) stalls--;
        feed_ready_i = rdy;
        @(posedge clk_i);
        #1;
        cyc++;
        if (rdy) begin
          if (t == 2 * N - 2) fin = 1'b1;
          else t++;
        end
      end
    end
    feed_ready_i = 1'b1;
    if (!aborted) begin
      total++;
      if (!fin || done_o !== 1'b1 || feed_valid_o !== 1'b0 || busy_o !== 1'b1)
        $display("FAIL done_pulse: fin %0d done %b valid %b busy %b required 1 1 0 1", fin, done_o, feed_valid_o, busy_o);
      else passed++;
    end
  endtask

  task automatic finish_done();
    @(posedge clk_i);
    #1;
    total++;
    if (done_o !== 1'b0 || in_ready_o !== 1'b1 || busy_o !== 1'b0 || feed_valid_o !== 1'b0)
      $display("FAIL after_done: done %b ready %b busy %b valid %b required 0 1 0 0", done_o, in_ready_o, busy_o, feed_valid_o);
    else passed++;
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({in_ready_o, feed_valid_o, feed_first_o, feed_last_o, done_o, busy_o} !== 6'b0 ||
        a_west_o !== '0 || b_north_o !== '0)
      $display("FAIL %s: flags %b a %h b %h required all 0", name,
               {in_ready_o, feed_valid_o, feed_first_o, feed_last_o, done_o, busy_o}, a_west_o, b_north_o);
    else passed++;
  endtask

  task automatic test_reset();
    #12;
    check_all_zero("reset_state");
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    total++;
    if (in_ready_o !== 1'b0) $display("FAIL ready_before_edge: got %b required 0", in_ready_o);
    else passed++;
    @(posedge clk_i);
    #1;
    total++;
    if (in_ready_o !== 1'b1) $display("FAIL ready_after_release: got %b required 1", in_ready_o);
    else passed++;
  endtask

  task automatic test_idle();
    bit seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (feed_valid_o || done_o || busy_o) seen = 1'b1;
      @(posedge clk_i);
      #1;
    end
    total++;
    if (seen) $display("FAIL idle: activity seen %0d required 0", seen);
    else passed++;
  endtask

  task automatic test_basic();
    int lc, fc;
    load_pair(1, 1'b0, lc);
    total++;
    if (lc != N) $display("FAIL basic_load_cycles: got %0d required %0d", lc, N);
    else passed++;
    total++;
    if (a_west_o !== 16'h0000 || b_north_o !== 16'h0001 || feed_first_o !== 1'b1)
      $display("FAIL basic_t0: a %h b %h first %b required 0000 0001 1", a_west_o, b_north_o, feed_first_o);
    else passed++;
    feed_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i);
      #1;
    end
    total++;
    if (a_west_o !== 16'hDA74 || b_north_o !== 16'h47AD)
      $display("FAIL basic_t3: a %h b %h required da74 47ad", a_west_o, b_north_o);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i);
      #1;
    end
    total++;
    if (a_west_o !== 16'hF000 || b_north_o !== 16'hF000 || feed_last_o !== 1'b1)
      $display("FAIL basic_t6: a %h b %h last %b required f000 f000 1", a_west_o, b_north_o, feed_last_o);
    else passed++;
    @(posedge clk_i);
    #1;
    total++;
    if (done_o !== 1'b1 || feed_valid_o !== 1'b0) $display("FAIL basic_done: done %b valid %b required 1 0", done_o, feed_valid_o);
    else passed++;
    finish_done();
    load_pair(1, 1'b0, lc);
    run_feed(-1, 0, -1, fc);
    total++;
    if (fc != 2 * N - 1) $display("FAIL basic_feed_cycles: got %0d required %0d", fc, 2 * N - 1);
    else passed++;
    finish_done();
  endtask

  task automatic test_stall();
    int lc, fc;
    load_pair(1, 1'b0, lc);
    run_feed(2, 3, -1, fc);
    total++;
    if (fc != 2 * N - 1 + 3) $display("FAIL stall_cycles: got %0d required %0d", fc, 2 * N - 1 + 3);
    else passed++;
    finish_done();
  endtask

  task automatic test_gaps();
    int lc, fc;
    load_pair(2, 1'b1, lc);
    total++;
    if (lc != 2 * N - 1) $display("FAIL gap_load_cycles: got %0d required %0d", lc, 2 * N - 1);
    else passed++;
    run_feed(-1, 0, -1, fc);
    finish_done();
  endtask

  task automatic test_reset_mid_feed();
    int lc, fc;
    bit seen = 1'b0;
    load_pair(1, 1'b0, lc);
    run_feed(-1, 0, 4, fc);
    rst_ni = 1'b0;
    #1;
    check_all_zero("reset_mid_feed");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i);
      #1;
      if (done_o) seen = 1'b1;
    end
    #1;
    rst_ni = 1'b1;
    #1;
    total++;
    if (seen || in_ready_o !== 1'b0) $display("FAIL reset_hold: done_seen %0d ready %b required 0 0", seen, in_ready_o);
    else passed++;
    @(posedge clk_i);
    #1;
    total++;
    if (in_ready_o !== 1'b1) $display("FAIL reset_recover_ready: got %b required 1", in_ready_o);
    else passed++;
    load_pair(1, 1'b0, lc);
    run_feed(-1, 0, -1, fc);
    finish_done();
  endtask

  task automatic test_back_to_back();
    int lc, fc;
    load_pair(1, 1'b0, lc);
    run_feed(-1, 0, -1, fc);
    load_pair(2, 1'b0, lc);
    total++;
    if (lc != N + 1) $display("FAIL b2b_load_cycles: got %0d required %0d", lc, N + 1);
    else passed++;
    run_feed(-1, 0, -1, fc);
    finish_done();
  endtask

  initial begin
    m1a[0] = 16'h4320; m1a[1] = 16'h8765; m1a[2] = 16'hCBA9; m1a[3] = 16'hFFED;
    m1b[0] = 16'h4321; m1b[1] = 16'h8765; m1b[2] = 16'hCBA9; m1b[3] = 16'hFFED;
    m2a[0] = 16'h1234; m2a[1] = 16'h5678; m2a[2] = 16'h9ABC; m2a[3] = 16'hDEF0;
    m2b[0] = 16'h0F1E; m2b[1] = 16'h2D3C; m2b[2] = 16'h4B5A; m2b[3] = 16'h6978;
    for (int k = 0; k < N; k++) begin
      cur_a[k] = '0;
      cur_b[k] = '0;
    end
    test_reset();
    test_idle();
    test_basic();
    test_stall();
    test_gaps();
    test_reset_mid_feed();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
